// File: rtl/conv_pkg.sv
// Types and constants shared by the convolution datapath blocks.
package conv_pkg;

    localparam int PIX_W = 8;

    typedef logic signed [PIX_W-1:0] pix_t;
    typedef logic [3:0][PIX_W-1:0]   window_t;

    // Byte positions inside a window, matching the conv_neuron kernel order
    localparam int WIN_TL = 3;
    localparam int WIN_TR = 2;
    localparam int WIN_BL = 1;
    localparam int WIN_BR = 0;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } win_state_e;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, 2x2 window stream out, for conv_window_gen.
interface conv_window_gen_if;
    import conv_pkg::*;

    pix_t    pix_in;
    logic    pix_valid;
    window_t pixels;
    logic    win_valid;
    logic    win_last;
    logic    frame_done;

    modport master (
        output pix_in, pix_valid,
        input  pixels, win_valid, win_last, frame_done
    );

    modport slave (
        input  pix_in, pix_valid,
        output pixels, win_valid, win_last, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// Enable-gated shift register; tail is the entry written DEPTH enables ago.
module line_buffer
    import conv_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter type data_t = pix_t
) (
    input  logic  clk,
    input  logic  en,
    input  data_t din,
    output data_t tail
);

    data_t mem [DEPTH];

    // Data is never reset: every slot is rewritten during the first row
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tail = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 2x2 window generator: raster pixels in, one registered window per
// pixel at row >= 1 and col >= 1, packed in conv_neuron kernel byte order.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_gen_if.slave  bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    win_state_e    state_q;
    win_state_e    state_d;
    pix_t          tail;
    pix_t          left_cur;
    pix_t          left_up;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          emit;

    // A pixel presented during reset is discarded, so it must not shift in
    assign accept   = bus.pix_valid & rst_n;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);
    assign emit     = bus.pix_valid && (state_q == STREAM) && (col != '0);

    line_buffer #(
        .DEPTH  (IMG_W),
        .data_t (pix_t)
    ) u_line_buffer (
        .clk  (clk),
        .en   (accept),
        .din  (bus.pix_in),
        .tail (tail)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (bus.pix_valid && last_col) state_d = STREAM;
            STREAM:  if (bus.pix_valid && last_col && last_row) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (bus.pix_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Left registers give (r, c-1) and (r-1, c-1); col 0 never emits,
    // so their stale contents across a row boundary are harmless
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_cur <= '0;
            left_up  <= '0;
        end else if (bus.pix_valid) begin
            left_cur <= bus.pix_in;
            left_up  <= tail;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.pixels     <= '0;
            bus.win_valid  <= 1'b0;
            bus.win_last   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.win_valid  <= emit;
            bus.win_last   <= emit && last_row && last_col;
            bus.frame_done <= bus.pix_valid && (state_q == STREAM) && last_row && last_col;
            if (emit) begin
                bus.pixels[WIN_TL] <= left_up;
                bus.pixels[WIN_TR] <= tail;
                bus.pixels[WIN_BL] <= left_cur;
                bus.pixels[WIN_BR] <= bus.pix_in;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a 4x3 instance for streaming,
// gaps, back-to-back frames and mid-frame reset, plus a 2x2 instance.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct {
        logic [31:0] win;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;

    conv_window_gen_if bus ();
    conv_window_gen_if bus2 ();

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    conv_window_gen #(.IMG_W(2), .IMG_H(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    int          winCount   = 0;
    exp_t        expQ [$];
    logic [7:0]  img [H][W];
    int          modelRow = 0;
    int          modelCol = 0;
    bit          gapMode  = 0;
    bit          prevValid = 0;
    logic [31:0] lastWin = '0;
    exp_t        popped;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        else
            passCount++;
    endtask

    // Drive one accepted pixel and push the window it should produce
    task automatic applyStimulus(input logic [7:0] v);
        exp_t e;
        @(negedge clk);
        bus.pix_in    = v;
        bus.pix_valid = 1'b1;
        img[modelRow][modelCol] = v;
        if (modelRow >= 1 && modelCol >= 1) begin
            e.win  = {img[modelRow-1][modelCol-1], img[modelRow-1][modelCol],
                      img[modelRow][modelCol-1], v};
            e.last = (modelRow == H-1) && (modelCol == W-1);
            expQ.push_back(e);
        end
        if (modelCol == W-1) begin
            modelCol = 0;
            modelRow = (modelRow == H-1) ? 0 : modelRow + 1;
        end else begin
            modelCol++;
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'hA5;
    endtask

    task automatic sendFrame(input logic [7:0] base, input bit gaps);
        for (int i = 0; i < W*H; i++) begin
            applyStimulus(base + 8'(i));
            if (gaps) idleCycle();
        end
    endtask

    task automatic endTest(input string tag, input int expWindows);
        repeat (4) idleCycle();
        checkOutput({tag, "_queue_empty"}, 32'(expQ.size()), 0);
        checkOutput({tag, "_win_count"}, 32'(winCount), 32'(expWindows));
        winCount = 0;
    endtask

    always @(negedge clk) begin
        if (bus.win_valid) begin
            winCount++;
            if (gapMode && prevValid) checkOutput("gap_back_to_back", 1, 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_window", 1, 0);
            end else begin
                popped = expQ.pop_front();
                checkOutput("pixels", bus.pixels, popped.win);
                checkOutput("win_last", {31'd0, bus.win_last}, {31'd0, popped.last});
                checkOutput("frame_done", {31'd0, bus.frame_done}, {31'd0, popped.last});
                lastWin = popped.win;
            end
        end else begin
            if (bus.win_last || bus.frame_done)
                checkOutput("stray_last_or_done", {30'd0, bus.win_last, bus.frame_done}, 0);
            if (gapMode) checkOutput("hold_pixels", bus.pixels, lastWin);
        end
        prevValid = bus.win_valid;
    end

    initial begin
        rst_n          = 1'b0;
        bus.pix_in     = '0;
        bus.pix_valid  = 1'b0;
        bus2.pix_in    = '0;
        bus2.pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_pixels", bus.pixels, 0);
        checkOutput("reset_flags", {29'd0, bus.win_valid, bus.win_last, bus.frame_done}, 0);
        checkOutput("reset_pixels_2x2", bus2.pixels, 0);
        rst_n = 1'b1;

        $display("[TB] continuous frame");
        sendFrame(8'h00, 1'b0);
        endTest("continuous", 6);

        $display("[TB] frame with gaps");
        gapMode = 1;
        sendFrame(8'h00, 1'b1);
        endTest("gaps", 6);
        gapMode = 0;

        $display("[TB] back-to-back frames");
        sendFrame(8'h00, 1'b0);
        sendFrame(8'h10, 1'b0);
        endTest("back_to_back", 12);

        $display("[TB] reset mid-frame");
        for (int i = 0; i <= 6; i++) applyStimulus(8'(i));
        @(negedge clk);
        rst_n         = 1'b0;
        bus.pix_in    = 8'h55;
        bus.pix_valid = 1'b1;
        @(negedge clk);
        checkOutput("midreset_pixels", bus.pixels, 0);
        checkOutput("midreset_flags", {29'd0, bus.win_valid, bus.win_last, bus.frame_done}, 0);
        expQ.delete();
        modelRow      = 0;
        modelCol      = 0;
        winCount      = 0;
        rst_n         = 1'b1;
        bus.pix_valid = 1'b0;
        sendFrame(8'h20, 1'b0);
        endTest("after_reset", 6);

        $display("[TB] 2x2 image");
        @(negedge clk);
        bus2.pix_in = 8'h01; bus2.pix_valid = 1'b1;
        @(negedge clk);
        bus2.pix_in = 8'hFF;
        @(negedge clk);
        bus2.pix_in = 8'hFF;
        @(negedge clk);
        checkOutput("2x2_no_window_col0", {31'd0, bus2.win_valid}, 0);
        bus2.pix_in = 8'h01;
        @(negedge clk);
        bus2.pix_valid = 1'b0;
        checkOutput("2x2_pixels", bus2.pixels, 32'h01ffff01);
        checkOutput("2x2_flags", {29'd0, bus2.win_valid, bus2.win_last, bus2.frame_done}, 32'h7);
        @(negedge clk);
        checkOutput("2x2_strobe_single", {31'd0, bus2.win_valid}, 0);
        checkOutput("2x2_pixels_held", bus2.pixels, 32'h01ffff01);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
